// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding instruction-memory
// read at a time and hands each instruction with its PC to decode.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  output logic            io_mem_req_valid,
  input  logic            io_mem_req_ready,
  output logic [XLEN-1:0] io_mem_req_addr,
  input  logic            io_mem_resp_valid,
  input  logic [XLEN-1:0] io_mem_resp_data,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [XLEN-1:0] io_out_inst,
  output logic [XLEN-1:0] io_out_pc,
  input  logic            io_redirect_valid,
  input  logic [XLEN-1:0] io_redirect_pc
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] inst_q_reg, inst_q_next;
  logic [XLEN-1:0] pc_q_reg, pc_q_next;
  logic            kill_reg, kill_next;
  logic [XLEN-1:0] redirect_target;
  logic            out_fire;

  assign redirect_target  = io_redirect_pc & ~XLEN'(3);
  assign io_mem_req_valid = (state_reg == REQ);
  assign io_mem_req_addr  = pc_reg;
  // Redirect gates the handover so a wrong-path instruction never reaches decode.
  assign io_out_valid     = (state_reg == HOLD) && !io_redirect_valid;
  assign io_out_inst      = inst_q_reg;
  assign io_out_pc        = pc_q_reg;
  assign out_fire         = io_out_valid && io_out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= BOOT;
      pc_reg     <= RESET_PC;
      kill_reg   <= 1'b0;
      inst_q_reg <= '0;
      pc_q_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      kill_reg   <= kill_next;
      inst_q_reg <= inst_q_next;
      pc_q_reg   <= pc_q_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    kill_next   = kill_reg;
    inst_q_next = inst_q_reg;
    pc_q_next   = pc_q_reg;
    case (state_reg)
      BOOT: begin
        if (io_redirect_valid) pc_next = redirect_target;
        state_next = REQ;
      end
      REQ: begin
        if (io_redirect_valid) begin
          pc_next = redirect_target;
          // The old address was accepted alongside the redirect; its data is stale.
          if (io_mem_req_ready) begin
            state_next = WAIT;
            kill_next  = 1'b1;
          end
        end else if (io_mem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (io_redirect_valid) begin
          pc_next = redirect_target;
          if (io_mem_resp_valid) begin
            kill_next  = 1'b0;
            state_next = REQ;
          end else begin
            kill_next  = 1'b1;
          end
        end else if (io_mem_resp_valid) begin
          if (kill_reg) begin
            kill_next  = 1'b0;
            state_next = REQ;
          end else begin
            inst_q_next = io_mem_resp_data;
            pc_q_next   = pc_reg;
            state_next  = HOLD;
          end
        end
      end
      HOLD: begin
        if (io_redirect_valid) begin
          pc_next    = redirect_target;
          state_next = REQ;
        end else if (out_fire) begin
          pc_next    = pc_reg + XLEN'(4);
          state_next = REQ;
        end
      end
      default: state_next = BOOT;
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: expected requests and deliveries are queued by the
// stimulus and consumed by a monitor as the DUT handshakes them.
module tb_ifu_fetch;

  logic        clock;
  logic        reset;
  logic        io_mem_req_valid;
  logic        io_mem_req_ready;
  logic [31:0] io_mem_req_addr;
  logic        io_mem_resp_valid;
  logic [31:0] io_mem_resp_data;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_inst;
  logic [31:0] io_out_pc;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_pc;

  ifu_fetch dut (
    .clock             (clock),
    .reset             (reset),
    .io_mem_req_valid  (io_mem_req_valid),
    .io_mem_req_ready  (io_mem_req_ready),
    .io_mem_req_addr   (io_mem_req_addr),
    .io_mem_resp_valid (io_mem_resp_valid),
    .io_mem_resp_data  (io_mem_resp_data),
    .io_out_valid      (io_out_valid),
    .io_out_ready      (io_out_ready),
    .io_out_inst       (io_out_inst),
    .io_out_pc         (io_out_pc),
    .io_redirect_valid (io_redirect_valid),
    .io_redirect_pc    (io_redirect_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int req_cnt = 0;
  int out_cnt = 0;
  int mem_lat = 1;
  int hs_cyc[$];
  logic [31:0] exp_req[$];
  logic [31:0] exp_out_pc[$];
  logic [31:0] exp_out_inst[$];

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_req(input logic [31:0] a);
    exp_req.push_back(a);
  endtask

  task automatic push_out(input logic [31:0] p, input logic [31:0] i);
    exp_out_pc.push_back(p);
    exp_out_inst.push_back(i);
  endtask

  task automatic wait_req(input int n);
    int k = 0;
    while (req_cnt < n && k < 200) begin step(); k++; end
    chk("wait_req_count", req_cnt, n);
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (out_cnt < n && k < 200) begin step(); k++; end
    chk("wait_out_count", out_cnt, n);
  endtask

  task automatic wait_outvalid();
    int k = 0;
    while (!io_out_valid && k < 200) begin step(); k++; end
    chk("wait_out_valid", {31'd0, io_out_valid}, 32'd1);
  endtask

  // Memory model: returns ~addr, mem_lat cycles after acceptance; abandoned on reset.
  initial begin
    logic        hs;
    logic [31:0] a;
    logic [31:0] paddr;
    int          cnt;
    io_mem_resp_valid = 1'b0;
    io_mem_resp_data  = '0;
    cnt = 0;
    paddr = '0;
    forever begin
      @(negedge clock);
      hs = reset && io_mem_req_valid && io_mem_req_ready;
      a  = io_mem_req_addr;
      @(posedge clock);
      #1;
      io_mem_resp_valid = 1'b0;
      if (!reset) cnt = 0;
      if (hs) begin
        paddr = a;
        cnt   = mem_lat;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          io_mem_resp_valid = 1'b1;
          io_mem_resp_data  = ~paddr;
        end
      end
    end
  end

  // Monitor: consumes expectations on each request and delivery handshake.
  always @(negedge clock) begin
    logic [31:0] e, ep;
    if (reset && io_mem_req_valid && io_mem_req_ready) begin
      req_cnt++;
      if (exp_req.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_req: got addr %h expected none", io_mem_req_addr);
      end else begin
        e = exp_req.pop_front();
        chk("req_addr", io_mem_req_addr, e);
        $display("req  #%0d addr=%h", req_cnt, io_mem_req_addr);
      end
    end
    if (reset && io_out_valid && io_out_ready) begin
      out_cnt++;
      hs_cyc.push_back(cyc);
      if (exp_out_pc.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_out: got pc %h inst %h expected none", io_out_pc, io_out_inst);
      end else begin
        ep = exp_out_pc.pop_front();
        e  = exp_out_inst.pop_front();
        chk("out_pc", io_out_pc, ep);
        chk("out_inst", io_out_inst, e);
        $display("out  #%0d pc=%h inst=%h", out_cnt, io_out_pc, io_out_inst);
      end
    end
  end

  initial begin
    reset = 1'b1;
    io_mem_req_ready  = 1'b1;
    io_out_ready      = 1'b1;
    io_redirect_valid = 1'b0;
    io_redirect_pc    = '0;
    #3 reset = 1'b0;
    @(negedge clock);
    chk("rst_req_valid", {31'd0, io_mem_req_valid}, 32'd0);
    chk("rst_req_addr",  io_mem_req_addr, 32'h8000_0000);
    chk("rst_out_valid", {31'd0, io_out_valid}, 32'd0);
    chk("rst_out_inst",  io_out_inst, 32'h0);
    chk("rst_out_pc",    io_out_pc, 32'h0);

    // Sequential fetch, then a decode stall on 0x8000000C.
    push_req(32'h8000_0000); push_req(32'h8000_0004); push_req(32'h8000_0008);
    push_req(32'h8000_000C); push_req(32'h8000_0010);
    push_out(32'h8000_0000, 32'h7FFF_FFFF); push_out(32'h8000_0004, 32'h7FFF_FFFB);
    push_out(32'h8000_0008, 32'h7FFF_FFF7); push_out(32'h8000_000C, 32'h7FFF_FFF3);
    step();
    reset = 1'b1;
    @(negedge clock);
    chk("boot_no_req", {31'd0, io_mem_req_valid}, 32'd0);
    wait_out(3);
    chk("spacing_1", hs_cyc[1] - hs_cyc[0], 32'd3);
    chk("spacing_2", hs_cyc[2] - hs_cyc[1], 32'd3);

    io_out_ready = 1'b0;
    wait_outvalid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("stall_out_valid", {31'd0, io_out_valid}, 32'd1);
      chk("stall_out_pc",    io_out_pc, 32'h8000_000C);
      chk("stall_out_inst",  io_out_inst, 32'h7FFF_FFF3);
      chk("stall_no_req",    {31'd0, io_mem_req_valid}, 32'd0);
      step();
    end
    io_out_ready = 1'b1;
    mem_lat = 3;

    // Redirect during WAIT; the old response lands two cycles later and is dropped.
    wait_req(5);
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 32'h8000_0103;
    push_req(32'h8000_0100);
    push_out(32'h8000_0100, 32'h7FFF_FEFF);
    mem_lat = 1;
    step();
    io_redirect_valid = 1'b0;
    wait_out(5);

    // Redirect in the same cycle as the response.
    push_req(32'h8000_0104);
    mem_lat = 2;
    wait_req(7);
    step();
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 32'h8000_0200;
    push_req(32'h8000_0200);
    step();
    io_redirect_valid = 1'b0;
    @(negedge clock);
    chk("redir_resp_req_valid", {31'd0, io_mem_req_valid}, 32'd1);
    chk("redir_resp_req_addr",  io_mem_req_addr, 32'h8000_0200);
    mem_lat = 1;

    // Redirect in HOLD with decode ready: nothing is handed over.
    wait_outvalid();
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 32'h8000_0300;
    push_req(32'h8000_0300);
    @(negedge clock);
    chk("hold_redir_out_valid", {31'd0, io_out_valid}, 32'd0);
    chk("hold_buf_pc",   io_out_pc, 32'h8000_0200);
    chk("hold_buf_inst", io_out_inst, 32'h7FFF_FDFF);
    step();
    // Redirect in REQ with ready: the accepted request is wrong-path.
    io_redirect_pc = 32'h8000_0400;
    push_req(32'h8000_0400);
    push_out(32'h8000_0400, 32'h7FFF_FBFF);
    step();
    io_redirect_valid = 1'b0;
    wait_out(6);

    // Reset while waiting on a response.
    push_req(32'h8000_0404);
    mem_lat = 3;
    wait_req(11);
    reset = 1'b0;
    #1;
    chk("mid_rst_req_valid", {31'd0, io_mem_req_valid}, 32'd0);
    chk("mid_rst_req_addr",  io_mem_req_addr, 32'h8000_0000);
    chk("mid_rst_out_valid", {31'd0, io_out_valid}, 32'd0);
    chk("mid_rst_out_inst",  io_out_inst, 32'h0);
    chk("mid_rst_out_pc",    io_out_pc, 32'h0);
    step();
    step();
    push_req(32'h8000_0000);
    push_out(32'h8000_0000, 32'h7FFF_FFFF);
    mem_lat = 1;
    reset = 1'b1;
    @(negedge clock);
    chk("reboot_no_req", {31'd0, io_mem_req_valid}, 32'd0);
    step();
    @(negedge clock);
    chk("reboot_req_valid", {31'd0, io_mem_req_valid}, 32'd1);
    chk("reboot_req_addr",  io_mem_req_addr, 32'h8000_0000);
    wait_out(7);

    // Redirect in REQ without ready, then PC wrap past 0xFFFFFFFC.
    io_mem_req_ready  = 1'b0;
    io_redirect_valid = 1'b1;
    io_redirect_pc    = 32'hFFFF_FFFF;
    push_req(32'hFFFF_FFFC); push_out(32'hFFFF_FFFC, 32'h0000_0003);
    push_req(32'h0000_0000); push_out(32'h0000_0000, 32'hFFFF_FFFF);
    push_req(32'h0000_0004);
    step();
    io_redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("stall_req_valid", {31'd0, io_mem_req_valid}, 32'd1);
      chk("stall_req_addr",  io_mem_req_addr, 32'hFFFF_FFFC);
      step();
    end
    io_mem_req_ready = 1'b1;
    wait_out(9);
    io_out_ready = 1'b0;
    wait_req(15);
    repeat (6) step();
    chk("exp_req_left", exp_req.size(), 32'd0);
    chk("exp_out_left", exp_out_pc.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage that sits directly upstream of decode and the immediate generator; supplies the 32-bit instruction word that decode slices for opcode and immediate fields.
- Owns the PC and issues one outstanding read at a time to instruction memory over a valid/ready request channel plus a response-valid channel.
- Presents each fetched instruction with its PC to decode over a valid/ready handshake.
- Accepts redirects (jump/branch target) from execute and discards wrong-path fetches.

Parameters:
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset.
- XLEN, 32, address and instruction width. Only 32 is supported.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- io_mem_req_valid  output  1  fetch request valid.
- io_mem_req_ready  input  1  memory accepts the request this cycle.
- io_mem_req_addr  output  32  fetch address, word aligned.
- io_mem_resp_valid  input  1  read data valid. Asserted exactly once per accepted request, at least 1 cycle after acceptance.
- io_mem_resp_data  input  32  instruction word.
- io_out_valid  output  1  instruction available to decode.
- io_out_ready  input  1  decode accepts the instruction.
- io_out_inst  output  32  instruction to decode and immediate generation.
- io_out_pc  output  32  PC of io_out_inst.
- io_redirect_valid  input  1  redirect the fetch stream.
- io_redirect_pc  input  32  target PC. Bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=BOOT, pc=RESET_PC, kill=0.
  - inst_q=0, pc_q=0.
  - All outputs are 0, except io_mem_req_addr, which equals RESET_PC.
- Internal registers:
  - pc: next fetch address.
  - kill: the outstanding response is wrong-path.
  - inst_q, pc_q: 1-entry output buffer.
- Output decode:
  - io_mem_req_valid = (state==REQ).
  - io_mem_req_addr = pc.
  - io_out_valid = (state==HOLD) && !io_redirect_valid. This is a deliberate combinational gate, so a wrong-path instruction is never handed over.
  - io_out_inst = inst_q; io_out_pc = pc_q.
- State transitions (redirect has priority in every state):
  - BOOT -> REQ on the first edge after reset deasserts. No request is issued in BOOT.
  - REQ, no redirect:
    - req_ready=1 -> WAIT.
    - Otherwise hold. Addr stays stable while valid is high; valid is never dropped without a handshake unless a redirect arrives.
  - REQ with redirect:
    - pc <= redirect_pc.
    - If req_ready=1 the same cycle, the old request has been accepted: WAIT with kill <= 1.
    - Otherwise stay in REQ; the new address is presented next cycle.
  - WAIT, no redirect, resp_valid=1:
    - kill=0 -> inst_q <= resp_data, pc_q <= pc, HOLD.
    - kill=1 -> discard, kill <= 0, REQ.
  - WAIT with redirect:
    - pc <= redirect_pc.
    - If resp_valid=1 the same cycle, discard data, kill <= 0, REQ.
    - Otherwise kill <= 1, stay in WAIT.
  - HOLD:
    - out_valid && out_ready -> pc <= pc + 4 (modulo 2^32, wraps 0xFFFF_FFFC -> 0), REQ.
    - Otherwise hold; inst_q and pc_q stay stable.
  - HOLD with redirect: drop the buffer, pc <= redirect_pc, REQ. No transfer occurs, because out_valid is gated low.
- Latency and throughput:
  - Zero-wait memory gives: request cycle, response one cycle later, io_out_valid the cycle after the response.
  - Minimum 3 cycles per instruction; no prefetch.
- pc advances only on an out handshake or a redirect.
- A response arriving in any state other than WAIT is a protocol violation. Verification asserts it never happens.
- Reset mid-operation (any state) returns immediately to the reset values. A pending memory response is the memory's responsibility to abandon.

Test Plan:
- Reset release; mem ready=1 with 1-cycle response; decode ready=1 -> requests to 0x80000000, 0x80000004, 0x80000008. Each io_out_pc/io_out_inst pair matches the memory word. Out handshake every 3 cycles.
- Decode ready=0 for 5 cycles in HOLD -> io_out_inst and io_out_pc stable, no new request, pc unchanged. Ready=1 -> next request at pc+4.
- Redirect to 0x80000103 during WAIT; old response arrives 2 cycles later -> response discarded, no out_valid. Next request at 0x80000100, and its instruction appears with io_out_pc=0x80000100.
- Redirect in the same cycle as resp_valid in WAIT -> data dropped, REQ next cycle at the redirect target, kill=0.
- Redirect while in HOLD with out_ready=1 -> io_out_valid=0 that cycle (no transfer), next request at the redirect target. Also: redirect in REQ with req_ready=1 -> first response discarded.
- Assert reset in WAIT -> outputs go to reset values immediately. After release, BOOT for 1 cycle, then a request to 0x80000000. Separately, redirect to 0xFFFFFFFC then accept -> next fetch at 0x00000000.
